// File: rtl/max_result_fifo.sv
// Captures each find_max result with a wrapping frame tag into a small FWFT FIFO.
// Results arriving while the FIFO is full and not popping are dropped and counted.
module max_result_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TAG_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     done,
  input  logic [WIDTH-1:0]         max_val,
  input  logic                     out_ready,
  input  logic                     clr_ovf,
  output logic                     out_valid,
  output logic [WIDTH-1:0]         out_data,
  output logic [TAG_W-1:0]         out_tag,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic [7:0]               drop_cnt
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] val_mem [DEPTH];
  logic [TAG_W-1:0] tag_mem [DEPTH];
  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;
  logic [TAG_W-1:0] ftag;

  logic          pop_c;
  logic          push_c;
  logic          drop_c;
  logic          full_c;
  logic [CW-1:0] cnt_nxt_c;

  // Handshake decode and next occupancy; a full FIFO still accepts a write while popping.
  always_comb begin
    pop_c     = out_valid & out_ready;
    full_c    = (count == CW'(DEPTH));
    push_c    = done & (~full_c | pop_c);
    drop_c    = done & full_c & ~pop_c;
    cnt_nxt_c = count;
    case ({push_c, pop_c})
      2'b10:   cnt_nxt_c = count + CW'(1);
      2'b01:   cnt_nxt_c = count - CW'(1);
      default: cnt_nxt_c = count;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        val_mem[i] <= '0;
        tag_mem[i] <= '0;
      end
      wptr      <= '0;
      rptr      <= '0;
      ftag      <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      overflow  <= 1'b0;
      drop_cnt  <= '0;
    end else begin
      if (push_c) begin
        val_mem[wptr] <= max_val;
        tag_mem[wptr] <= ftag;
        wptr          <= wptr + PW'(1);
      end
      if (pop_c) begin
        rptr <= rptr + PW'(1);
      end
      if (done) begin
        ftag <= ftag + TAG_W'(1);
      end
      count     <= cnt_nxt_c;
      out_valid <= (cnt_nxt_c != '0);
      // A drop in the same cycle as a clear wins over the clear.
      if (drop_c) begin
        overflow <= 1'b1;
        if (clr_ovf) begin
          drop_cnt <= 8'd1;
        end else if (drop_cnt != 8'hFF) begin
          drop_cnt <= drop_cnt + 8'd1;
        end
      end else if (clr_ovf) begin
        overflow <= 1'b0;
        drop_cnt <= '0;
      end
    end
  end

  assign out_data = val_mem[rptr];
  assign out_tag  = tag_mem[rptr];

endmodule
